// File: rtl/msrh_lsu_pkg.sv
// LSU / L2 interface widths and memory command encoding.
package msrh_lsu_pkg;

    localparam int unsigned ICACHE_DATA_W = 64;
    localparam int unsigned L2_CMD_TAG_W  = 4;

    typedef enum logic [1:0] {
        M_XRD = 2'd0,
        M_XWR = 2'd1
    } mem_cmd_t;

endpackage

// File: rtl/riscv_pkg.sv
// RISC-V platform widths shared across the memory subsystem.
package riscv_pkg;

    localparam int unsigned PADDR_W = 56;

endpackage

// File: rtl/msrh_l2_req_arbiter.sv
// Three-port round-robin arbiter onto a single L2 request channel, with
// response routing back to the requester encoded in the top two tag bits.
module msrh_l2_req_arbiter #(
    parameter int unsigned DATA_W = msrh_lsu_pkg::ICACHE_DATA_W,
    parameter int unsigned TAG_W  = msrh_lsu_pkg::L2_CMD_TAG_W,
    parameter int unsigned ADDR_W = riscv_pkg::PADDR_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset,

    input  logic                      i_p0_req_valid,
    input  msrh_lsu_pkg::mem_cmd_t    i_p0_req_cmd,
    input  logic [ADDR_W-1:0]         i_p0_req_addr,
    input  logic [TAG_W-1:0]          i_p0_req_tag,
    input  logic [DATA_W-1:0]         i_p0_req_data,
    input  logic [DATA_W/8-1:0]       i_p0_req_byte_en,
    output logic                      o_p0_req_ready,
    output logic                      o_p0_resp_valid,
    output logic [TAG_W-1:0]          o_p0_resp_tag,
    output logic [DATA_W-1:0]         o_p0_resp_data,
    input  logic                      i_p0_resp_ready,

    input  logic                      i_p1_req_valid,
    input  msrh_lsu_pkg::mem_cmd_t    i_p1_req_cmd,
    input  logic [ADDR_W-1:0]         i_p1_req_addr,
    input  logic [TAG_W-1:0]          i_p1_req_tag,
    input  logic [DATA_W-1:0]         i_p1_req_data,
    input  logic [DATA_W/8-1:0]       i_p1_req_byte_en,
    output logic                      o_p1_req_ready,
    output logic                      o_p1_resp_valid,
    output logic [TAG_W-1:0]          o_p1_resp_tag,
    output logic [DATA_W-1:0]         o_p1_resp_data,
    input  logic                      i_p1_resp_ready,

    input  logic                      i_p2_req_valid,
    input  msrh_lsu_pkg::mem_cmd_t    i_p2_req_cmd,
    input  logic [ADDR_W-1:0]         i_p2_req_addr,
    input  logic [TAG_W-1:0]          i_p2_req_tag,
    input  logic [DATA_W-1:0]         i_p2_req_data,
    input  logic [DATA_W/8-1:0]       i_p2_req_byte_en,
    output logic                      o_p2_req_ready,
    output logic                      o_p2_resp_valid,
    output logic [TAG_W-1:0]          o_p2_resp_tag,
    output logic [DATA_W-1:0]         o_p2_resp_data,
    input  logic                      i_p2_resp_ready,

    output logic                      o_l2_req_valid,
    output msrh_lsu_pkg::mem_cmd_t    o_l2_req_cmd,
    output logic [ADDR_W-1:0]         o_l2_req_addr,
    output logic [TAG_W+1:0]          o_l2_req_tag,
    output logic [DATA_W-1:0]         o_l2_req_data,
    output logic [DATA_W/8-1:0]       o_l2_req_byte_en,
    input  logic                      i_l2_req_ready,

    input  logic                      i_l2_resp_valid,
    input  logic [TAG_W+1:0]          i_l2_resp_tag,
    input  logic [DATA_W-1:0]         i_l2_resp_data,
    output logic                      o_l2_resp_ready,

    output logic                      o_bad_tag_err
);

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned BE_W      = DATA_W / 8;

    function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] off);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    logic [NUM_PORTS-1:0]   req_valid;
    msrh_lsu_pkg::mem_cmd_t req_cmd  [NUM_PORTS];
    logic [ADDR_W-1:0]      req_addr [NUM_PORTS];
    logic [TAG_W-1:0]       req_tag  [NUM_PORTS];
    logic [DATA_W-1:0]      req_data [NUM_PORTS];
    logic [BE_W-1:0]        req_be   [NUM_PORTS];
    logic [NUM_PORTS-1:0]   resp_ready;

    assign req_valid  = {i_p2_req_valid, i_p1_req_valid, i_p0_req_valid};
    assign req_cmd    = '{i_p0_req_cmd, i_p1_req_cmd, i_p2_req_cmd};
    assign req_addr   = '{i_p0_req_addr, i_p1_req_addr, i_p2_req_addr};
    assign req_tag    = '{i_p0_req_tag, i_p1_req_tag, i_p2_req_tag};
    assign req_data   = '{i_p0_req_data, i_p1_req_data, i_p2_req_data};
    assign req_be     = '{i_p0_req_byte_en, i_p1_req_byte_en, i_p2_req_byte_en};
    assign resp_ready = {i_p2_resp_ready, i_p1_resp_ready, i_p0_resp_ready};

    // ---------------- request path ----------------
    logic                   l2_req_valid_q;
    msrh_lsu_pkg::mem_cmd_t l2_req_cmd_q;
    logic [ADDR_W-1:0]      l2_req_addr_q;
    logic [TAG_W+1:0]       l2_req_tag_q;
    logic [DATA_W-1:0]      l2_req_data_q;
    logic [BE_W-1:0]        l2_req_be_q;
    logic [1:0]             rr_ptr;

    logic       req_free;
    logic       grant_valid;
    logic [1:0] grant_port;
    logic       req_accept;
    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;

    // Reset counts as free so readies during reset reflect an empty buffer.
    assign req_free = !l2_req_valid_q || i_l2_req_ready || i_reset;

    assign cand0 = rr_ptr;
    assign cand1 = wrap_add(rr_ptr, 2'd1);
    assign cand2 = wrap_add(rr_ptr, 2'd2);

    // Round-robin search starting at rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 2'd0;
        if (req_valid[cand0]) begin
            grant_valid = 1'b1;
            grant_port  = cand0;
        end else if (req_valid[cand1]) begin
            grant_valid = 1'b1;
            grant_port  = cand1;
        end else if (req_valid[cand2]) begin
            grant_valid = 1'b1;
            grant_port  = cand2;
        end
    end

    assign req_accept     = grant_valid && req_free;
    assign o_p0_req_ready = req_accept && (grant_port == 2'd0);
    assign o_p1_req_ready = req_accept && (grant_port == 2'd1);
    assign o_p2_req_ready = req_accept && (grant_port == 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            l2_req_valid_q <= 1'b0;
            rr_ptr         <= 2'd0;
        end else if (req_accept) begin
            l2_req_valid_q <= 1'b1;
            rr_ptr         <= wrap_add(grant_port, 2'd1);
        end else if (i_l2_req_ready) begin
            l2_req_valid_q <= 1'b0;
        end
    end

    // Payload needs no reset; it is qualified by l2_req_valid_q.
    always_ff @(posedge i_clk) begin
        if (req_accept) begin
            l2_req_cmd_q  <= req_cmd[grant_port];
            l2_req_addr_q <= req_addr[grant_port];
            l2_req_tag_q  <= {grant_port, req_tag[grant_port]};
            l2_req_data_q <= req_data[grant_port];
            l2_req_be_q   <= req_be[grant_port];
        end
    end

    assign o_l2_req_valid   = l2_req_valid_q;
    assign o_l2_req_cmd     = l2_req_cmd_q;
    assign o_l2_req_addr    = l2_req_addr_q;
    assign o_l2_req_tag     = l2_req_tag_q;
    assign o_l2_req_data    = l2_req_data_q;
    assign o_l2_req_byte_en = l2_req_be_q;

    // ---------------- response path ----------------
    logic [NUM_PORTS-1:0] resp_vld_q;
    logic [TAG_W-1:0]     resp_tag_q;
    logic [DATA_W-1:0]    resp_data_q;
    logic                 bad_tag_q;

    logic [1:0]           in_port;
    logic [NUM_PORTS-1:0] in_dec;
    logic                 resp_drain;
    logic                 resp_load;

    assign in_port = i_l2_resp_tag[TAG_W+1:TAG_W];

    // Port ID 3 decodes to no target, so the entry is accepted and dropped.
    always_comb begin
        in_dec = '0;
        case (in_port)
            2'd0:    in_dec = 3'b001;
            2'd1:    in_dec = 3'b010;
            2'd2:    in_dec = 3'b100;
            default: in_dec = 3'b000;
        endcase
    end

    assign resp_drain      = |(resp_vld_q & resp_ready);
    assign o_l2_resp_ready = ~|resp_vld_q || resp_drain;
    assign resp_load       = i_l2_resp_valid && o_l2_resp_ready;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            resp_vld_q <= '0;
            bad_tag_q  <= 1'b0;
        end else if (resp_load) begin
            resp_vld_q <= in_dec;
            if (in_port == 2'd3) begin
                bad_tag_q <= 1'b1;
            end
        end else if (resp_drain) begin
            resp_vld_q <= '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (resp_load) begin
            resp_tag_q  <= i_l2_resp_tag[TAG_W-1:0];
            resp_data_q <= i_l2_resp_data;
        end
    end

    assign o_p0_resp_valid = resp_vld_q[0];
    assign o_p1_resp_valid = resp_vld_q[1];
    assign o_p2_resp_valid = resp_vld_q[2];
    assign o_p0_resp_tag   = resp_tag_q;
    assign o_p1_resp_tag   = resp_tag_q;
    assign o_p2_resp_tag   = resp_tag_q;
    assign o_p0_resp_data  = resp_data_q;
    assign o_p1_resp_data  = resp_data_q;
    assign o_p2_resp_data  = resp_data_q;
    assign o_bad_tag_err   = bad_tag_q;

endmodule
